// File: rtl/seq_nr_divider.sv
// Sequential non-restoring divider: one quotient bit per enabled clock.
// Signed mode divides magnitudes and re-applies signs in a single fix-up step.
module seq_nr_divider #(
    parameter int C_NUM_BITS = 24,
    parameter bit C_SIGNED   = 1'b0
) (
    input  logic                  CK,
    input  logic                  RN,
    input  logic                  E,
    input  logic                  START,
    input  logic [C_NUM_BITS-1:0] A,
    input  logic [C_NUM_BITS-1:0] B,
    output logic [C_NUM_BITS-1:0] Q,
    output logic [C_NUM_BITS-1:0] R,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  DZ
);

    localparam int N     = C_NUM_BITS;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [N-1:0]     ONE_N    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic signed [N:0]  rem_q, rem_d;
    logic        [N-1:0] quo_q, quo_d;
    logic        [N-1:0] div_q, div_d;
    logic                negq_q, negq_d;
    logic                negr_q, negr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic        [N-1:0] q_q, q_d;
    logic        [N-1:0] r_q, r_d;
    logic                dz_q, dz_d;

    logic signed [N:0]  rem_shift;
    logic signed [N:0]  div_ext;
    logic        [N-1:0] r_mag;
    logic                a_neg, b_neg;

    // Two's-complement negate when requested; also used to take magnitudes.
    function automatic logic [N-1:0] cond_negate(input logic [N-1:0] v, input logic neg);
        return neg ? ((~v) + ONE_N) : v;
    endfunction

    assign a_neg   = C_SIGNED & A[N-1];
    assign b_neg   = C_SIGNED & B[N-1];
    assign div_ext = $signed({1'b0, div_q});

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        r_d       = r_q;
        dz_d      = dz_q;
        rem_shift = '0;
        r_mag     = '0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    dz_d = 1'b0;
                    if (B == '0) begin
                        q_d     = '1;
                        r_d     = A;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = cond_negate(A, a_neg);
                        div_d   = cond_negate(B, b_neg);
                        negq_d  = a_neg ^ b_neg;
                        negr_d  = a_neg;
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                // Dividend bits shift out of quo_q's top while quotient bits fill its bottom.
                rem_shift = {rem_q[N-1:0], quo_q[N-1]};
                if (rem_q[N]) begin
                    rem_d = rem_shift + div_ext;
                end else begin
                    rem_d = rem_shift - div_ext;
                end
                quo_d = {quo_q[N-2:0], ~rem_d[N]};
                cnt_d = cnt_q + ONE_C;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                // Corrected remainder lies in [0, divisor), so N bits suffice.
                r_mag   = rem_q[N] ? (rem_q[N-1:0] + div_q) : rem_q[N-1:0];
                q_d     = cond_negate(quo_q, negq_q);
                r_d     = cond_negate(r_mag, negr_q);
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else if (E) begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign DZ   = dz_q;
    assign BUSY = (state_q == S_CALC) || (state_q == S_FIX);
    assign DONE = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_nr_divider.sv
// Directed bench for seq_nr_divider: a 24-bit unsigned and an 8-bit signed instance.
module tb_seq_nr_divider;

    logic CK = 1'b0;
    logic RN = 1'b1;

    logic        e24 = 1'b1, start24 = 1'b0;
    logic [23:0] a24 = '0, b24 = '0, q24, r24;
    logic        busy24, done24, dz24;

    logic        e8 = 1'b1, start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, q8, r8;
    logic        busy8, done8, dz8;

    logic        sel8 = 1'b0;
    logic [63:0] q_obs, r_obs;
    logic        busy_obs, done_obs, dz_obs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CK = ~CK;

    seq_nr_divider #(.C_NUM_BITS(24), .C_SIGNED(1'b0)) u_dut24 (
        .CK(CK), .RN(RN), .E(e24), .START(start24), .A(a24), .B(b24),
        .Q(q24), .R(r24), .BUSY(busy24), .DONE(done24), .DZ(dz24)
    );

    seq_nr_divider #(.C_NUM_BITS(8), .C_SIGNED(1'b1)) u_dut8s (
        .CK(CK), .RN(RN), .E(e8), .START(start8), .A(a8), .B(b8),
        .Q(q8), .R(r8), .BUSY(busy8), .DONE(done8), .DZ(dz8)
    );

    always_comb begin
        if (sel8) begin
            q_obs    = {56'd0, q8};
            r_obs    = {56'd0, r8};
            busy_obs = busy8;
            done_obs = done8;
            dz_obs   = dz8;
        end else begin
            q_obs    = {40'd0, q24};
            r_obs    = {40'd0, r24};
            busy_obs = busy24;
            done_obs = done24;
            dz_obs   = dz24;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present operands with START for one edge; returns at accept edge + 1.
    task automatic launch(input bit s8, input logic [63:0] a, input logic [63:0] b);
        sel8 = s8;
        if (s8) begin
            a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
        end else begin
            a24 = a[23:0]; b24 = b[23:0]; start24 = 1'b1;
        end
        @(posedge CK); #1;
        start8  = 1'b0;
        start24 = 1'b0;
    endtask

    task automatic wait_done(output int k, output int busy_n, output int qchg);
        logic [63:0] q0, r0;
        k = 0; busy_n = 0; qchg = 0;
        q0 = q_obs; r0 = r_obs;
        while (!done_obs && k < 200) begin
            if (busy_obs) busy_n++;
            @(posedge CK); #1;
            k++;
            if (busy_obs && (q_obs !== q0 || r_obs !== r0)) qchg++;
        end
    endtask

    task automatic run_op(input string tag, input bit s8, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] eq, input logic [63:0] er, input logic edz);
        int k, bn, qc, lat;
        lat = (b == 64'd0) ? 0 : (s8 ? 9 : 25);
        launch(s8, a, b);
        wait_done(k, bn, qc);
        check_eq({tag, "_lat"},   64'(k),  64'(lat));
        check_eq({tag, "_busy"},  64'(bn), 64'(lat));
        check_eq({tag, "_hold"},  64'(qc), 64'd0);
        check_eq({tag, "_q"},     q_obs,   eq);
        check_eq({tag, "_r"},     r_obs,   er);
        check_eq({tag, "_dz"},    64'(dz_obs), 64'(edz));
        @(posedge CK); #1;
        check_eq({tag, "_pulse"}, {62'd0, done_obs, busy_obs}, 64'd0);
    endtask

    initial begin
        int k, bn, qc, en, first, dn;
        logic d_before;

        #3 RN = 1'b0;
        repeat (2) @(posedge CK);
        #1;
        check_eq("rst_q24",  64'(q24), 64'd0);
        check_eq("rst_r24",  64'(r24), 64'd0);
        check_eq("rst_ctl24", {61'd0, busy24, done24, dz24}, 64'd0);
        check_eq("rst_ctl8",  {61'd0, busy8, done8, dz8}, 64'd0);
        RN = 1'b1;

        // 24-bit unsigned
        run_op("u_1000_7",   1'b0, 64'd1000,     64'd7,        64'd142,      64'd6,     1'b0);
        run_op("u_max_1",    1'b0, 64'hFFFFFF,   64'd1,        64'hFFFFFF,   64'd0,     1'b0);
        run_op("u_5_0",      1'b0, 64'd5,        64'd0,        64'hFFFFFF,   64'd5,     1'b1);
        run_op("u_7_1000",   1'b0, 64'd7,        64'd1000,     64'd0,        64'd7,     1'b0);
        run_op("u_max_max",  1'b0, 64'hFFFFFF,   64'hFFFFFF,   64'd1,        64'd0,     1'b0);
        run_op("u_hex",      1'b0, 64'h123456,   64'h001000,   64'h000123,   64'h456,   1'b0);

        // 8-bit signed
        run_op("s_m7_2",     1'b1, 64'hF9, 64'h02, 64'hFD, 64'hFF, 1'b0);
        run_op("s_7_m2",     1'b1, 64'h07, 64'hFE, 64'hFD, 64'h01, 1'b0);
        run_op("s_ovf",      1'b1, 64'h80, 64'hFF, 64'h80, 64'h00, 1'b0);
        run_op("s_m7_m2",    1'b1, 64'hF9, 64'hFE, 64'h03, 64'hFF, 1'b0);
        run_op("s_6_m3",     1'b1, 64'h06, 64'hFD, 64'hFE, 64'h00, 1'b0);
        run_op("s_m5_0",     1'b1, 64'hFB, 64'h00, 64'hFF, 64'hFB, 1'b1);
        run_op("s_m1_5",     1'b1, 64'hFF, 64'h05, 64'h00, 64'hFF, 1'b0);
        run_op("s_127_m128", 1'b1, 64'h7F, 64'h80, 64'h00, 64'h7F, 1'b0);
        run_op("s_m128_7",   1'b1, 64'h80, 64'h07, 64'hEE, 64'hFE, 1'b0);

        // Clock enable toggling every cycle
        sel8 = 1'b0;
        a24 = 24'd100; b24 = 24'd9; start24 = 1'b1; e24 = 1'b1;
        @(posedge CK); #1;
        start24 = 1'b0;
        en = 1; first = 0; dn = 0;
        for (int i = 0; i < 80; i++) begin
            d_before = done24;
            e24 = ~e24;
            @(posedge CK); #1;
            if (e24) begin
                en++;
                if (d_before) dn++;
            end
            if (done24 && first == 0) first = en;
        end
        e24 = 1'b1;
        check_eq("en_first_done", 64'(first), 64'd26);
        check_eq("en_done_cnt",   64'(dn),    64'd1);
        check_eq("en_q", 64'(q24), 64'd11);
        check_eq("en_r", 64'(r24), 64'd1);

        // START re-pulsed during CALC is ignored
        launch(1'b0, 64'd1000, 64'd7);
        repeat (5) @(posedge CK);
        #1;
        a24 = 24'd50; b24 = 24'd3; start24 = 1'b1;
        @(posedge CK); #1;
        start24 = 1'b0;
        wait_done(k, bn, qc);
        check_eq("ign_lat", 64'(k), 64'd19);
        check_eq("ign_q", 64'(q24), 64'd142);
        check_eq("ign_r", 64'(r24), 64'd6);

        // Asynchronous reset mid-CALC
        @(posedge CK); #1;
        launch(1'b0, 64'd1000, 64'd7);
        repeat (10) @(posedge CK);
        #1;
        RN = 1'b0;
        #1;
        check_eq("arst_q24", 64'(q24), 64'd0);
        check_eq("arst_r24", 64'(r24), 64'd0);
        check_eq("arst_ctl24", {61'd0, busy24, done24, dz24}, 64'd0);
        check_eq("arst_q8",  64'(q8), 64'd0);
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CK); #1;
            if (done24) dn++;
        end
        check_eq("arst_nodone", 64'(dn), 64'd0);
        RN = 1'b1;
        run_op("post_rst", 1'b0, 64'd100, 64'd9, 64'd11, 64'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_nr_divider.md
SEQ_NR_DIVIDER -- requirements
Module: seq_nr_divider

Interface
REQ-001 SHALL have parameter C_NUM_BITS, default 24: operand, quotient and remainder width; legal range 4..64.
REQ-002 SHALL have parameter C_SIGNED, default 0: 0 = unsigned, 1 = two's-complement truncating division.
REQ-003 SHALL have port CK  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port RN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port E  input  1  clock enable; when low, all state holds.
REQ-006 SHALL have port START  input  1  request to begin a division; sampled only in IDLE.
REQ-007 SHALL have port A  input  C_NUM_BITS  dividend, captured on the START-accept edge.
REQ-008 SHALL have port B  input  C_NUM_BITS  divisor, captured on the START-accept edge.
REQ-009 SHALL have port Q  output  C_NUM_BITS  quotient, registered.
REQ-010 SHALL have port R  output  C_NUM_BITS  remainder, registered.
REQ-011 SHALL have port BUSY  output  1  high in CALC and FIX.
REQ-012 SHALL have port DONE  output  1  single-cycle pulse: Q/R/DZ valid.
REQ-013 SHALL have port DZ  output  1  divide-by-zero flag for the last result.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE; an edge with E low changes no register.
REQ-015 IDLE: START=1 at an enabled edge SHALL capture A and B, clear DZ and go to CALC; if B==0 it SHALL go directly to DONE instead.
REQ-016 CALC SHALL run non-restoring division with a C_NUM_BITS+1-bit partial remainder, one quotient bit per enabled edge, for exactly C_NUM_BITS edges, counted by a ceil(log2(C_NUM_BITS+1))-bit iteration counter.
REQ-017 Per iteration: remainder non-negative -> shift left and subtract divisor; negative -> shift left and add divisor; quotient bit = NOT sign of the new remainder.
REQ-018 FIX SHALL last one edge: if the remainder is negative, add the divisor; in signed mode, apply result signs; then go to DONE.
REQ-019 DONE SHALL assert DONE for one enabled cycle, then return to IDLE; Q, R and DZ SHALL hold until the next accepted START.
REQ-020 Latency: for B!=0, DONE SHALL be high in the cycle after C_NUM_BITS+2 enabled edges following the accept edge; for B==0, after 1 edge.
REQ-021 START while BUSY or DONE SHALL be ignored, with no queuing.
REQ-022 B==0 SHALL give Q = all ones, R = A (unmodified), DZ = 1.
REQ-023 Unsigned: Q = floor(A/B), R = A - Q*B, with 0 <= R < B.
REQ-024 Signed (C_SIGNED=1): the core SHALL divide magnitudes; Q sign = sign(A) XOR sign(B), R sign = sign(A), zero results non-negative.
REQ-025 Signed overflow, A = -2^(N-1) and B = -1, SHALL give Q = -2^(N-1) (wraps), R = 0, DZ = 0.
REQ-026 Q and R SHALL NOT change during CALC/FIX; internal working registers SHALL be separate from the output registers.

Reset
REQ-027 RN low SHALL asynchronously force IDLE, Q=0, R=0, BUSY=0, DONE=0, DZ=0, and clear the counter and working registers.
REQ-028 RN asserted mid-CALC SHALL abort the operation, with no DONE pulse.
REQ-029 After RN deasserts, the first enabled edge with START=1 SHALL be accepted.

Verification
REQ-030 N=24 unsigned, A=1000, B=7, E=1 -> BUSY for 25 cycles, DONE at cycle 26, Q=142, R=6, DZ=0.
REQ-031 N=24 unsigned, A=0xFFFFFF, B=1 -> Q=0xFFFFFF, R=0; then A=5, B=0 -> DONE one cycle after accept, Q=0xFFFFFF, R=5, DZ=1.
REQ-032 N=8 signed: A=-7, B=2 -> Q=-3, R=-1; A=7, B=-2 -> Q=-3, R=1; A=-128, B=-1 -> Q=-128, R=0.
REQ-033 A=100, B=9, E toggled 1/0 every cycle -> same result (Q=11, R=1) after 26 enabled edges, with DONE asserted for exactly one enabled cycle.
REQ-034 START re-pulsed during CALC with different A/B -> ignored, original result delivered.
REQ-035 RN pulsed low at iteration 10 -> all outputs 0 immediately, no DONE, next START runs normally.
REQ-036 Random regression: 10k operand pairs per mode, N in {8,24,32}, checked against a reference model including B=0 and the signed overflow case.
